// File: rtl/line_mem_responder.sv
// -----------------------------------------------------------------------------
// line_mem_responder
//
// Backing-store model that serves whole cache lines to an L1 cache. Requests
// are serialized: one line fill or line writeback is in flight at a time, and
// a new request is only taken while the FSM sits in IDLE.
//
// A fill returns LINE_WORDS beats on the rsp_* channel. The first beat appears
// LATENCY cycles after the request is accepted. A writeback absorbs LINE_WORDS
// beats on the wr_* channel and then pulses wr_done for one cycle.
//
// Ports
//   clk_i          single clock, rising-edge
//   rst_ni         asynchronous active-low reset (memory contents survive it)
//   req_valid_i    line request present
//   req_ready_o    request accepted this cycle (high only in IDLE)
//   req_we_i       1 = writeback, 0 = fill
//   req_addr_i     byte address anywhere inside the line
//   wr_valid_i     writeback beat valid
//   wr_data_i      writeback beat data
//   wr_ready_o     writeback beat accepted (high only in WR_BURST)
//   wr_done_o      one-cycle pulse after the last writeback beat
//   rsp_valid_o    fill beat valid
//   rsp_data_o     fill beat data
//   rsp_last_o     final fill beat of the line
//   rsp_ready_i    cache accepts the fill beat
// -----------------------------------------------------------------------------
module line_mem_responder #(
  parameter int unsigned LINE_WORDS  = 4,     // words per line, power of two, >= 2
  parameter int unsigned DEPTH_WORDS = 1024,  // backing store size in 32-bit words
  parameter int unsigned LATENCY     = 3      // accept edge to first fill beat, >= 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic        wr_valid_i,
  input  logic [31:0] wr_data_i,
  output logic        wr_ready_o,
  output logic        wr_done_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_last_o,
  input  logic        rsp_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);  // word index width
  localparam int unsigned OW = $clog2(LINE_WORDS);   // word-in-line width
  localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [AW-1:0] OFFS_MASK = AW'(LINE_WORDS - 1);
  localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD_BURST,
    S_WR_BURST,
    S_WR_ACK
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [LW-1:0]   lat_cnt_q;
  logic [OW-1:0]   beat_cnt_q;
  logic [AW-1:0]   base_q;      // line-aligned word index of the active line
  logic            we_q;        // captured direction of the active request

  logic            req_ready_q;
  logic            wr_ready_q;
  logic            wr_done_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_data_q;
  logic            rsp_last_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  // ---------------------------------------------------------------------------
  // Address arithmetic and handshake qualifiers
  // ---------------------------------------------------------------------------
  logic [AW-1:0]   req_base_d;  // line base of the incoming request
  logic [AW-1:0]   cur_idx;     // word addressed by the current beat
  logic [AW-1:0]   nxt_idx;     // word addressed by the following beat
  logic [OW-1:0]   beat_inc;
  logic            wr_fire;
  logic            rsp_fire;

  // NOTE: every signal assigned in this block gets a value before any
  // condition is evaluated, so no path can leave one unassigned and infer a latch.
  always_comb begin
    // Drop the byte offset, keep AW word bits (modulo DEPTH_WORDS) and clear
    // the word-in-line bits so the base is always line-aligned.
    req_base_d = req_addr_i[AW+1:2] & ~OFFS_MASK;
    beat_inc   = beat_cnt_q + OW'(1);
    // Base is line-aligned, so these sums never carry out of the line and
    // the AW-bit width gives the modulo-DEPTH_WORDS wrap for free.
    cur_idx    = base_q + AW'(beat_cnt_q);
    nxt_idx    = base_q + AW'(beat_inc);
    // wr_ready/rsp_valid are high exactly in these states, so the state
    // test alone qualifies the handshakes.
    wr_fire    = (state_q == S_WR_BURST) && wr_valid_i;
    rsp_fire   = (state_q == S_RD_BURST) && rsp_ready_i;
  end

  // Byte-offset bits and address bits above the store size carry no meaning.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_i[31:AW+2], req_addr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Backing store
  // ---------------------------------------------------------------------------
  // NOTE: the array is deliberately left out of reset: a reset must not
  // disturb stored lines, and it keeps the store mappable onto RAM macros.
  // While rst_ni is low the FSM is held in IDLE, so wr_fire is low and no
  // half-finished writeback can land.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[cur_idx] <= wr_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      beat_cnt_q  <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && req_ready_q) begin
            state_q     <= S_WAIT;
            req_ready_q <= 1'b0;
            we_q        <= req_we_i;
            base_q      <= req_base_d;
            lat_cnt_q   <= LAT_LOAD;
          end
        end

        S_WAIT: begin
          if (lat_cnt_q == '0) begin
            beat_cnt_q <= '0;
            if (we_q) begin
              state_q    <= S_WR_BURST;
              wr_ready_q <= 1'b1;
            end else begin
              // First fill beat is registered here, landing exactly
              // LATENCY edges after the accepting edge.
              state_q     <= S_RD_BURST;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= mem_q[base_q];
              rsp_last_q  <= 1'b0;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end
        end

        S_RD_BURST: begin
          // Without rsp_ready nothing here changes, so the beat holds.
          if (rsp_fire) begin
            if (rsp_last_q) begin
              state_q     <= S_IDLE;
              req_ready_q <= 1'b1;
              beat_cnt_q  <= '0;
              rsp_valid_q <= 1'b0;
              rsp_last_q  <= 1'b0;
              rsp_data_q  <= '0;
            end else begin
              beat_cnt_q <= beat_inc;
              rsp_data_q <= mem_q[nxt_idx];
              rsp_last_q <= (beat_inc == LAST_BEAT);
            end
          end
        end

        S_WR_BURST: begin
          if (wr_fire) begin
            if (beat_cnt_q == LAST_BEAT) begin
              state_q    <= S_WR_ACK;
              beat_cnt_q <= '0;
              wr_ready_q <= 1'b0;
              wr_done_q  <= 1'b1;
            end else begin
              beat_cnt_q <= beat_inc;
            end
          end
        end

        S_WR_ACK: begin
          state_q     <= S_IDLE;
          wr_done_q   <= 1'b0;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          wr_ready_q  <= 1'b0;
          wr_done_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign wr_ready_o  = wr_ready_q;
  assign wr_done_o   = wr_done_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_last_o  = rsp_last_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_line_mem_responder
//
// Table of writeback/fill transactions with hand-computed line contents,
// followed by two hand-written sequences: a request held high across a burst,
// and a reset that lands in the middle of a writeback. Fill beats are checked
// by a negedge monitor against a queue of expected beats filled when each fill
// request is issued.
// -----------------------------------------------------------------------------
module tb_line_mem_responder;

  localparam int LINE_WORDS  = 4;
  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        wr_done;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_ready = 1'b0;

  always #5 clk = ~clk;

  line_mem_responder #(
    .LINE_WORDS (LINE_WORDS),
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i   (req_we),
    .req_addr_i (req_addr),
    .wr_valid_i (wr_valid),
    .wr_data_i  (wr_data),
    .wr_ready_o (wr_ready),
    .wr_done_o  (wr_done),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o (rsp_data),
    .rsp_last_o (rsp_last),
    .rsp_ready_i(rsp_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic             we;
    logic [31:0]      addr;
    logic [3:0][31:0] d;       // writeback data or expected fill data
    logic             toggle;  // gappy wr_valid / toggled rsp_ready
  } vec_t;

  beat_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic tog);
    vec_t v;
    v.we     = we;
    v.addr   = addr;
    v.d[0]   = d0;
    v.d[1]   = d1;
    v.d[2]   = d2;
    v.d[3]   = d3;
    v.toggle = tog;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Fill-beat monitor: compares each accepted beat against the queue and checks
  // that a stalled beat holds its data and last flag.
  // ---------------------------------------------------------------------------
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else if (rsp_valid) begin
      if (prev_stall) begin
        check("rsp_data_stable", rsp_data, prev_data);
        check("rsp_last_stable", 32'(rsp_last), 32'(prev_last));
      end
      if (rsp_ready) begin
        check("rsp_beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_last", 32'(rsp_last), 32'(e.last));
        end
        prev_stall = 1'b0;
      end else begin
        prev_stall = 1'b1;
        prev_data  = rsp_data;
        prev_last  = rsp_last;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction tasks (all entered and left at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic issue_req(input logic we, input logic [31:0] addr, input bit hold,
                           output int waited);
    logic acc;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    acc       = 1'b0;
    waited    = 0;
    while (!acc && waited < 50) begin
      acc = req_ready;
      @(posedge clk); #1;
      if (!acc) waited++;
    end
    if (!hold) req_valid = 1'b0;
    check("req_accepted", 32'(acc), 32'd1);
  endtask

  task automatic do_wb(input logic [31:0] addr, input logic [3:0][31:0] d, input logic gappy);
    int   w;
    int   b;
    int   cyc;
    int   rdy_cycles;
    logic v;
    logic rdy;
    issue_req(1'b1, addr, 1'b0, w);
    check("wb_accept_wait", w, 0);
    b = 0;
    cyc = 0;
    rdy_cycles = 0;
    while (b < LINE_WORDS && cyc < 40) begin
      v = gappy ? cyc[0] : 1'b1;
      wr_valid = v;
      wr_data  = v ? d[b] : 32'hDEAD_BEEF;
      rdy = wr_ready;
      if (rdy) rdy_cycles++;
      @(posedge clk); #1;
      cyc++;
      if (v && rdy) b++;
    end
    wr_valid = 1'b0;
    wr_data  = 32'hDEAD_BEEF;
    check("wb_beats", b, LINE_WORDS);
    if (!gappy) check("wb_ready_cycles", rdy_cycles, LINE_WORDS);
    check("wr_done_pulse", 32'(wr_done), 32'd1);
    check("wr_ready_after_last", 32'(wr_ready), 32'd0);
    check("req_ready_in_ack", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("wr_done_single", 32'(wr_done), 32'd0);
    check("req_ready_after_ack", 32'(req_ready), 32'd1);
  endtask

  task automatic do_fill(input logic [31:0] addr, input logic [3:0][31:0] d, input logic tog);
    beat_t b;
    int    w;
    int    k;
    int    cyc;
    bit    pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < LINE_WORDS; i++) begin
      b.data = d[i];
      b.last = (i == LINE_WORDS - 1);
      exp_q.push_back(b);
    end
    issue_req(1'b0, addr, 1'b0, w);
    check("fill_accept_wait", w, 0);
    check("fill_valid_at_accept", 32'(rsp_valid), 32'd0);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("fill_latency", k, LATENCY);
    cyc = 0;
    while (!(req_ready && !rsp_valid) && cyc < 100) begin
      rsp_ready = tog ? pat[cyc % 4] : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    rsp_ready = 1'b0;
    check("fill_complete", 32'(req_ready), 32'd1);
    check("fill_beats_left", exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    vec_t  vecs[8];
    vec_t  tmp;
    beat_t eb;
    int    w;
    int    b;
    int    cyc;
    int    hi;
    logic  done;
    logic  rdy;

    vecs[0] = mk(1'b1, 32'h0000_0100, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0);
    vecs[1] = mk(1'b0, 32'h0000_010C, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0);
    vecs[2] = mk(1'b1, 32'h0000_3FF0, 32'hA000_0000, 32'hA000_0001,
                 32'hA000_0002, 32'hA000_0003, 1'b1);
    vecs[3] = mk(1'b1, 32'h0000_0003, 32'hB000_0000, 32'hB000_0001,
                 32'hB000_0002, 32'hB000_0003, 1'b0);
    vecs[4] = mk(1'b0, 32'h0000_3FF0, 32'hA000_0000, 32'hA000_0001,
                 32'hA000_0002, 32'hA000_0003, 1'b1);
    vecs[5] = mk(1'b0, 32'h0000_4000, 32'hB000_0000, 32'hB000_0001,
                 32'hB000_0002, 32'hB000_0003, 1'b0);
    vecs[6] = mk(1'b1, 32'h0000_0200, 32'hC000_0000, 32'hC000_0001,
                 32'hC000_0002, 32'hC000_0003, 1'b1);
    vecs[7] = mk(1'b0, 32'h0000_020C, 32'hC000_0000, 32'hC000_0001,
                 32'hC000_0002, 32'hC000_0003, 1'b1);

    // Reset state, applied asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_wr_done", 32'(wr_done), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Table-driven transactions.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].we) do_wb(vecs[i].addr, vecs[i].d, vecs[i].toggle);
      else            do_fill(vecs[i].addr, vecs[i].d, vecs[i].toggle);
    end

    // Request held high across a fill: the second request is accepted only
    // on the edge after the burst returns to IDLE.
    for (int i = 0; i < LINE_WORDS; i++) begin
      eb.data = vecs[0].d[i];
      eb.last = (i == LINE_WORDS - 1);
      exp_q.push_back(eb);
    end
    for (int i = 0; i < LINE_WORDS; i++) begin
      eb.data = vecs[6].d[i];
      eb.last = (i == LINE_WORDS - 1);
      exp_q.push_back(eb);
    end
    rsp_ready = 1'b1;
    issue_req(1'b0, 32'h0000_0100, 1'b1, w);
    req_addr = 32'h0000_020C;
    hi = 0;
    done = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      if (req_ready) hi++;
      done = rsp_valid && rsp_last;
      @(posedge clk); #1;
      cyc++;
    end
    check("busy_req_ready_high", hi, 0);
    check("idle_after_last_beat", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("held_req_accepted", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    cyc = 0;
    while (!(req_ready && !rsp_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    rsp_ready = 1'b0;
    check("held_fill_complete", 32'(req_ready), 32'd1);
    check("held_beats_left", exp_q.size(), 0);

    // Reset after two of four writeback beats to line 0x100.
    issue_req(1'b1, 32'h0000_0100, 1'b0, w);
    b = 0;
    cyc = 0;
    while (b < 2 && cyc < 20) begin
      wr_valid = 1'b1;
      wr_data  = (b == 0) ? 32'h55 : 32'h66;
      rdy = wr_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy) b++;
    end
    check("abort_beats_written", b, 2);
    wr_data = 32'h77;
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_wr_ready", 32'(wr_ready), 32'd0);
    check("abort_wr_done", 32'(wr_done), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_last", 32'(rsp_last), 32'd0);
    check("abort_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    // First request after reset release is taken on the first rising edge.
    tmp = mk(1'b0, 32'h0000_0104, 32'h55, 32'h66, 32'h33, 32'h44, 1'b0);
    do_fill(tmp.addr, tmp.d, tmp.toggle);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
